mod_sysbus_responder: RTL and testbench
=======================================

Name: mod_sysbus_responder

Overview:
- Memory-side responder for the system bus; the endpoint the cache/memory arbiter issues requests to.
- Accepts one line-sized request at a time (64-byte lines) and serves it from an internal line-organised store.
- Read: returns 8 beats of 64 bits after a fixed latency.
- Write: absorbs 8 data beats following the address beat. Used as the memory model in simulation and as the on-chip backing store.

Parameters:
- DATA_WIDTH, 64, bus beat width in bits; line = 8 beats.
- TAG_WIDTH, 13, request/response tag width; MSB encodes direction (1 = READ, 0 = WRITE).
- MEM_LINES, 256, number of 64-byte lines in the store; power of two.
- READ_LATENCY, 4, cycles from reqack pulse to first read beat; legal range is at least 1.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- reqcyc  input  1  request beat valid.
- req  input  DATA_WIDTH  address on the first beat; write data on subsequent beats.
- reqtag  input  TAG_WIDTH  request tag, sampled on the address beat only.
- reqack  output  1  one-cycle acceptance pulse per captured request beat.
- respcyc  output  1  read response beat valid.
- resp  output  DATA_WIDTH  read data beat.
- resptag  output  TAG_WIDTH  tag of the request being answered.
- respack  input  1  requester accepts the current response beat.

Behaviour:
- Reset (reset = 0, async): state IDLE; reqack, respcyc, resp, resptag, beat counter and latency counter all 0. Store contents are not cleared. The store initialises to all-zero at time 0.
- Beat capture rule: a request beat is captured at a rising edge where reqcyc = 1 and reqack = 0. reqack goes 1 for exactly the following cycle. reqcyc while reqack = 1 is ignored, because the requester updates req on the edge that sees reqack.
- Address mapping: index = req[6 +: log2(MEM_LINES)]; bits [5:0] ignored; upper bits alias.
- Beat k (0..7) maps to 64-bit word k of the line. No byte swapping is done; byte order is the requester's concern.
- IDLE: capture address beat, latch index and reqtag, pulse reqack.
  - reqtag MSB = 1 -> RLAT, latency counter = READ_LATENCY-1.
  - reqtag MSB = 0 -> WDATA, beat counter = 0.
- RLAT: counter decrements each cycle; at 0 -> RBURST.
  - First respcyc is high exactly READ_LATENCY cycles after the reqack-high cycle.
- RBURST:
  - respcyc = 1; resp = word[beat]; resptag = latched tag.
  - Outputs are held stable while respack = 0.
  - At an edge with respack = 1: beat increments and the next word is presented in the next cycle with no bubble.
  - After beat 7 is accepted: respcyc = 0, resp = 0, -> IDLE.
  - respack tied to respcyc yields 8 consecutive beats.
- WDATA:
  - Each captured beat writes req into word[beat] of the latched line at the capture edge, then beat increments.
  - After the 8th data beat: -> IDLE. No response beat is ever issued for writes; respcyc stays 0 throughout.
- reqack is never high in RLAT or RBURST.
  - reqcyc asserted during RLAT/RBURST is left pending, not dropped, and is captured in IDLE.
  - The earliest next-request capture is the edge after the last respack edge, i.e. the first cycle in IDLE.
- respack while respcyc = 0 is ignored.
- Reset mid-burst: immediate return to IDLE with outputs 0.
  - Partially written lines keep the words already written.
  - A pending read is abandoned with no residual beats.
- Single outstanding request; no pipelining between requests.

Test Plan:
- Read line 0x40 after reset with respack tied to respcyc -> reqack pulse one cycle after reqcyc; respcyc high 4 cycles after the pulse; 8 beats all 0x0; resptag equals reqtag (e.g. 0x1001); respcyc low afterwards.
- Write to address 0x1C0 (reqtag 0x0005) with data beats 0x11..0x88 replicated per byte, then read 0x1C0 -> 9 reqack pulses each separated by at least one low cycle; no respcyc during write; read returns the beats in order 0x1111111111111111 .. 0x8888888888888888.
- Read with respack held 0 for 3 cycles on beat 2 -> resp stays word 2 and respcyc stays 1 during the stall; remaining beats follow; total 8 distinct beats.
- Aliasing with MEM_LINES = 256: write 0x4000_0040, read 0x0000_0040 and 0x0000_0047 -> both return the written data.
- reset pulled low during read beat 3, released, then a new read issued -> respcyc drops asynchronously; new read starts at beat 0 with the correct latency.
- reqcyc held high into RBURST for a second read -> no reqack until the burst completes; second request acked the cycle after IDLE capture; its first beat appears exactly READ_LATENCY cycles after that ack.

Source files
------------

// File: rtl/mod_sysbus_responder_if.sv
// System bus request/response bundle between a requester and the responder.
// master: drives reqcyc/req/reqtag/respack; slave: drives reqack/respcyc/resp/resptag.
interface mod_sysbus_responder_if #(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 13
);
    logic                  reqcyc;
    logic [DATA_WIDTH-1:0] req;
    logic [TAG_WIDTH-1:0]  reqtag;
    logic                  reqack;
    logic                  respcyc;
    logic [DATA_WIDTH-1:0] resp;
    logic [TAG_WIDTH-1:0]  resptag;
    logic                  respack;

    modport master (
        output reqcyc, req, reqtag, respack,
        input  reqack, respcyc, resp, resptag
    );

    modport slave (
        input  reqcyc, req, reqtag, respack,
        output reqack, respcyc, resp, resptag
    );
endinterface

// File: rtl/mod_sysbus_responder.sv
// Memory-side system bus responder: 64-byte line reads/writes, 8 beats each.
// Ports: clk, reset (async active-low), bus (slave side of the sysbus interface).
module mod_sysbus_responder #(
    parameter int DATA_WIDTH   = 64,
    parameter int TAG_WIDTH    = 13,
    parameter int MEM_LINES    = 256,
    parameter int READ_LATENCY = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    mod_sysbus_responder_if.slave    bus
);
    localparam int IDX_W = $clog2(MEM_LINES);
    // Counter only ever holds READ_LATENCY-1 down to 0.
    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        RLAT,
        RBURST,
        WDATA
    } state_t;

    // Store is zero at time 0 and deliberately never cleared by reset.
    logic [DATA_WIDTH-1:0] mem [MEM_LINES*8] = '{default: '0};

    state_t                state_q, state_d;
    logic                  reqack_q, reqack_d;
    logic                  respcyc_q, respcyc_d;
    logic [DATA_WIDTH-1:0] resp_q, resp_d;
    logic [TAG_WIDTH-1:0]  resptag_q, resptag_d;
    logic [2:0]            beat_q, beat_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;

    logic                  capture;
    logic                  wr_en;
    logic [2:0]            rd_beat;
    logic [DATA_WIDTH-1:0] rd_word;

    // A beat is taken only when no ack is outstanding; the requester
    // changes req on the edge that sees reqack, so that cycle is skipped.
    assign capture = bus.reqcyc && !reqack_q &&
                     (state_q == IDLE || state_q == WDATA);

    // Word to present on the next cycle: beat 0 on burst entry,
    // otherwise the one after the beat being accepted.
    assign rd_beat = (state_q == RBURST) ? beat_q + 3'd1 : 3'd0;
    assign rd_word = mem[{idx_q, rd_beat}];

    always_comb begin
        state_d   = state_q;
        reqack_d  = capture;
        respcyc_d = respcyc_q;
        resp_d    = resp_q;
        resptag_d = resptag_q;
        beat_d    = beat_q;
        lat_d     = lat_q;
        idx_d     = idx_q;
        tag_d     = tag_q;
        wr_en     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (capture) begin
                    idx_d = bus.req[6 +: IDX_W];
                    tag_d = bus.reqtag;
                    if (bus.reqtag[TAG_WIDTH-1]) begin
                        state_d = RLAT;
                        lat_d   = LAT_INIT;
                    end else begin
                        state_d = WDATA;
                        beat_d  = 3'd0;
                    end
                end
            end
            RLAT: begin
                if (lat_q == '0) begin
                    state_d   = RBURST;
                    beat_d    = 3'd0;
                    respcyc_d = 1'b1;
                    resp_d    = rd_word;
                    resptag_d = tag_q;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            RBURST: begin
                if (bus.respack) begin
                    if (beat_q == 3'd7) begin
                        state_d   = IDLE;
                        beat_d    = 3'd0;
                        respcyc_d = 1'b0;
                        resp_d    = '0;
                    end else begin
                        beat_d = beat_q + 3'd1;
                        resp_d = rd_word;
                    end
                end
            end
            WDATA: begin
                if (capture) begin
                    wr_en  = 1'b1;
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            reqack_q  <= 1'b0;
            respcyc_q <= 1'b0;
            resp_q    <= '0;
            resptag_q <= '0;
            beat_q    <= 3'd0;
            lat_q     <= '0;
            idx_q     <= '0;
            tag_q     <= '0;
        end else begin
            state_q   <= state_d;
            reqack_q  <= reqack_d;
            respcyc_q <= respcyc_d;
            resp_q    <= resp_d;
            resptag_q <= resptag_d;
            beat_q    <= beat_d;
            lat_q     <= lat_d;
            idx_q     <= idx_d;
            tag_q     <= tag_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{idx_q, beat_q}] <= bus.req;
        end
    end

    assign bus.reqack  = reqack_q;
    assign bus.respcyc = respcyc_q;
    assign bus.resp    = resp_q;
    assign bus.resptag = resptag_q;
endmodule

// File: tb/tb_mod_sysbus_responder.sv
// Self-checking bench for mod_sysbus_responder: directed table, corner
// sequences and random traffic checked against a line-array model.
module tb_mod_sysbus_responder;
    localparam int READ_LATENCY = 4;
    localparam int MEM_LINES    = 256;

    logic clk;
    logic reset;

    mod_sysbus_responder_if #(.DATA_WIDTH(64), .TAG_WIDTH(13)) bus_if ();

    mod_sysbus_responder #(
        .DATA_WIDTH  (64),
        .TAG_WIDTH   (13),
        .MEM_LINES   (MEM_LINES),
        .READ_LATENCY(READ_LATENCY)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [63:0] addr;
        logic [12:0] tag;
        logic [63:0] base;
        logic [63:0] step;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] model_mem [MEM_LINES][8];
    logic [63:0] got [8];
    logic [63:0] wbuf [8];
    int          resp_in_req;
    int          ack_in_burst;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int line_of(input logic [63:0] a);
        return int'(a[6 +: 8]);
    endfunction

    // Drive one request beat from a negedge and wait for its ack.
    task automatic send_beat(input logic [63:0] data, input logic [12:0] tag,
                             input bit last, output int w);
        bus_if.reqcyc = 1'b1;
        bus_if.req    = data;
        bus_if.reqtag = tag;
        w = 0;
        do begin
            @(negedge clk);
            w++;
            if (bus_if.respcyc) resp_in_req++;
        end while (!bus_if.reqack && w < 64);
        chk("ack_seen", 64'(bus_if.reqack), 64'd1);
        if (last) bus_if.reqcyc = 1'b0;
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [12:0] tag);
        int w;
        resp_in_req = 0;
        send_beat(addr, tag, 1'b0, w);
        chk("wr_addr_ack_wait", 64'(w), 64'd1);
        for (int k = 0; k < 8; k++) begin
            send_beat(wbuf[k], tag, k == 7, w);
            chk("wr_data_ack_wait", 64'(w), 64'd2);
            model_mem[line_of(addr)][k] = wbuf[k];
        end
        @(negedge clk);
        if (bus_if.respcyc) resp_in_req++;
        chk("wr_no_respcyc", 64'(resp_in_req), 64'd0);
    endtask

    // Entered at the negedge of the address ack; returns in the first
    // idle cycle after the last beat was accepted.
    task automatic collect_burst(input logic [12:0] tag, input int stall_beat,
                                 input int stall_n);
        int lat = 0;
        ack_in_burst = 0;
        while (!bus_if.respcyc && lat < 64) begin
            @(negedge clk);
            lat++;
            if (bus_if.reqack) ack_in_burst++;
        end
        chk("rd_latency", 64'(lat), 64'(READ_LATENCY));
        for (int b = 0; b < 8; b++) begin
            if (b > 0) chk("rd_no_bubble", 64'(bus_if.respcyc), 64'd1);
            got[b] = bus_if.resp;
            chk("rd_resptag", 64'(bus_if.resptag), 64'(tag));
            if (b == stall_beat) begin
                for (int s = 0; s < stall_n; s++) begin
                    bus_if.respack = 1'b0;
                    @(negedge clk);
                    if (bus_if.reqack) ack_in_burst++;
                    chk("stall_respcyc", 64'(bus_if.respcyc), 64'd1);
                    chk("stall_resp", bus_if.resp, got[b]);
                end
            end
            bus_if.respack = 1'b1;
            @(negedge clk);
            bus_if.respack = 1'b0;
            if (bus_if.reqack) ack_in_burst++;
        end
        chk("rd_end_respcyc", 64'(bus_if.respcyc), 64'd0);
        chk("rd_end_resp", bus_if.resp, 64'd0);
        chk("no_ack_in_burst", 64'(ack_in_burst), 64'd0);
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [12:0] tag,
                           input int stall_beat, input int stall_n);
        int w;
        resp_in_req = 0;
        send_beat(addr, tag, 1'b1, w);
        chk("rd_ack_wait", 64'(w), 64'd1);
        collect_burst(tag, stall_beat, stall_n);
    endtask

    vec_t vt [6];

    initial begin
        int w;
        int lat;
        logic [63:0] a;
        logic [12:0] t;

        for (int l = 0; l < MEM_LINES; l++)
            for (int k = 0; k < 8; k++) model_mem[l][k] = '0;

        vt[0] = '{1'b0, 64'h40,        13'h1001, 64'h0, 64'h0};
        vt[1] = '{1'b1, 64'h1C0,       13'h0005,
                  64'h1111111111111111, 64'h1111111111111111};
        vt[2] = '{1'b0, 64'h1C0,       13'h1005,
                  64'h1111111111111111, 64'h1111111111111111};
        vt[3] = '{1'b1, 64'h4000_0040, 13'h0007,
                  64'hA5A5_0000_0000_0000, 64'h1};
        vt[4] = '{1'b0, 64'h0000_0040, 13'h1FFF,
                  64'hA5A5_0000_0000_0000, 64'h1};
        vt[5] = '{1'b0, 64'h0000_0047, 13'h1ABC,
                  64'hA5A5_0000_0000_0000, 64'h1};

        reset          = 1'b0;
        bus_if.reqcyc  = 1'b0;
        bus_if.req     = '0;
        bus_if.reqtag  = '0;
        bus_if.respack = 1'b0;
        #2;
        chk("rst_reqack", 64'(bus_if.reqack), 64'd0);
        chk("rst_respcyc", 64'(bus_if.respcyc), 64'd0);
        chk("rst_resp", bus_if.resp, 64'd0);
        chk("rst_resptag", 64'(bus_if.resptag), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            if (vt[i].wr) begin
                for (int k = 0; k < 8; k++)
                    wbuf[k] = vt[i].base + 64'(k) * vt[i].step;
                do_write(vt[i].addr, vt[i].tag);
            end else begin
                do_read(vt[i].addr, vt[i].tag, 8, 0);
                for (int k = 0; k < 8; k++)
                    chk($sformatf("vec%0d_beat%0d", i, k), got[k],
                        vt[i].base + 64'(k + 1) * vt[i].step - vt[i].step);
            end
        end

        // Stall three cycles on beat 2.
        do_read(64'h1C0, 13'h1010, 2, 3);
        for (int k = 0; k < 8; k++)
            chk("stall_beat", got[k], model_mem[7][k]);

        // Reset while beat 3 is on the bus.
        send_beat(64'h1C0, 13'h1333, 1'b1, w);
        lat = 0;
        while (!bus_if.respcyc && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        for (int b = 0; b < 3; b++) begin
            bus_if.respack = 1'b1;
            @(negedge clk);
            bus_if.respack = 1'b0;
        end
        chk("rst_pre_beat3", bus_if.resp, model_mem[7][3]);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_respcyc", 64'(bus_if.respcyc), 64'd0);
        chk("rst_mid_resp", bus_if.resp, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_read(64'h1C0, 13'h1444, 8, 0);
        for (int k = 0; k < 8; k++)
            chk("post_rst_beat", got[k], model_mem[7][k]);

        // Second read held pending through the first burst.
        send_beat(64'h1C0, 13'h1111, 1'b0, w);
        bus_if.req    = 64'h40;
        bus_if.reqtag = 13'h1222;
        collect_burst(13'h1111, 8, 0);
        for (int k = 0; k < 8; k++)
            chk("pend_first_beat", got[k], model_mem[7][k]);
        chk("pend_idle_noack", 64'(bus_if.reqack), 64'd0);
        @(negedge clk);
        chk("pend_ack", 64'(bus_if.reqack), 64'd1);
        bus_if.reqcyc = 1'b0;
        collect_burst(13'h1222, 8, 0);
        for (int k = 0; k < 8; k++)
            chk("pend_second_beat", got[k], model_mem[1][k]);

        // Random traffic against the line-array model.
        for (int n = 0; n < 40; n++) begin
            a = {$urandom(), $urandom()};
            if ($urandom_range(0, 1) == 1) begin
                t = {1'b0, 12'($urandom())};
                for (int k = 0; k < 8; k++)
                    wbuf[k] = {$urandom(), $urandom()};
                do_write(a, t);
            end else begin
                t = {1'b1, 12'($urandom())};
                do_read(a, t, $urandom_range(0, 8), $urandom_range(1, 3));
                for (int k = 0; k < 8; k++)
                    chk("rand_beat", got[k], model_mem[line_of(a)][k]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
